// File: rtl/cipher_job_scheduler_pkg.sv
// rtl/cipher_job_scheduler_pkg.sv - shared types and constants for the cipher job scheduler
package cipher_sched_pkg;

    localparam int BLK_W                  = 128;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/cipher_job_scheduler_if.sv
// rtl/cipher_job_scheduler_if.sv - requester job/response ports and cipher core handshake
interface cipher_job_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import cipher_sched_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [BLK_W*NUM_REQ-1:0] req_text;
    logic [BLK_W*NUM_REQ-1:0] req_key;
    logic [NUM_REQ-1:0]       req_decrypt;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [BLK_W-1:0]         resp_data;
    logic                     resp_err;
    logic                     core_start;
    logic [BLK_W-1:0]         core_text;
    logic [BLK_W-1:0]         core_key;
    logic                     core_decrypt;
    logic                     core_done;
    logic [BLK_W-1:0]         core_result;
    logic                     core_abort;
    logic                     busy;
    logic [ID_W-1:0]          grant_id;

    modport slave (
        input  req_valid, req_text, req_key, req_decrypt, resp_ready, core_done, core_result,
        output req_ready, resp_valid, resp_data, resp_err, core_start, core_text, core_key,
               core_decrypt, core_abort, busy, grant_id
    );

    modport master (
        output req_valid, req_text, req_key, req_decrypt, resp_ready, core_done, core_result,
        input  req_ready, resp_valid, resp_data, resp_err, core_start, core_text, core_key,
               core_decrypt, core_abort, busy, grant_id
    );

endinterface

// File: rtl/cipher_job_scheduler_rr_arbiter.sv
// rtl/cipher_job_scheduler_rr_arbiter.sv - combinational round-robin pick starting at the pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_i} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_i[cand[ID_W-1:0]]) begin
                found                    = 1'b1;
                gnt_o[cand[ID_W-1:0]]    = 1'b1;
                idx_o                    = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cipher_job_scheduler.sv
// rtl/cipher_job_scheduler.sv - round-robin sharing of one cipher core between NUM_REQ requesters
// Optional core watchdog enabled by defining CIPHER_TIMEOUT_EN.
module cipher_job_scheduler
    import cipher_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    cipher_job_scheduler_if.slave  bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [BLK_W-1:0]   text_q, text_d;
    logic [BLK_W-1:0]   key_q, key_d;
    logic [BLK_W-1:0]   rdata_q, rdata_d;
    logic               dec_q, dec_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               accept;
    logic               done_seen;
    logic               timeout;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign accept    = (state_q == S_IDLE) && (|bus.req_valid) && !reset;
    assign done_seen = (state_q == S_WAIT) && bus.core_done;

`ifdef CIPHER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_q, wd_d;

    // Held at zero outside WAIT, so it restarts on every WAIT entry.
    always_comb begin
        wd_d = '0;
        if (state_q == S_WAIT) begin
            wd_d = wd_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    // A done arriving on the limit cycle takes priority over the abort.
    assign timeout = (state_q == S_WAIT) && !bus.core_done &&
                     (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            text_q  <= '0;
            key_q   <= '0;
            rdata_q <= '0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            text_q  <= text_d;
            key_q   <= key_d;
            rdata_q <= rdata_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (done_seen || timeout) state_d = S_RESP;
            S_RESP:  if (bus.resp_ready[gid_q]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        text_d  = text_q;
        key_d   = key_q;
        dec_d   = dec_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            ptr_d  = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
            gid_d  = arb_idx;
            text_d = bus.req_text[arb_idx*BLK_W +: BLK_W];
            key_d  = bus.req_key[arb_idx*BLK_W +: BLK_W];
            dec_d  = bus.req_decrypt[arb_idx];
        end
        if (done_seen) begin
            rdata_d = bus.core_result;
            err_d   = 1'b0;
        end else if (timeout) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        if (accept) begin
            bus.req_ready = arb_gnt;
        end
        if (state_q == S_RESP) begin
            bus.resp_valid[gid_q] = 1'b1;
        end
        bus.core_start = (state_q == S_ISSUE);
        bus.core_abort = timeout;
        bus.busy       = (state_q != S_IDLE);
    end

    assign bus.resp_data    = rdata_q;
    assign bus.resp_err     = err_q;
    assign bus.core_text    = text_q;
    assign bus.core_key     = key_q;
    assign bus.core_decrypt = dec_q;
    assign bus.grant_id     = gid_q;

endmodule
